// File: rtl/video_pkg.sv
// Shared constants for the video scan-out stage: raster timing defaults, CRAM layout
// and colour-index helpers.
package video_pkg;

  localparam int unsigned H_TOTAL_DEF      = 342;
  localparam int unsigned H_ACTIVE_DEF     = 256;
  localparam int unsigned H_SYNC_START_DEF = 280;
  localparam int unsigned H_SYNC_LEN_DEF   = 26;
  localparam int unsigned V_TOTAL_DEF      = 262;
  localparam int unsigned V_ACTIVE_DEF     = 192;
  localparam int unsigned V_SYNC_START_DEF = 216;
  localparam int unsigned V_SYNC_LEN_DEF   = 3;

  localparam int unsigned CRAM_DEPTH = 32;
  localparam int unsigned CRAM_W     = 6;
  // CRAM entry layout is {B[1:0], G[1:0], R[1:0]}
  localparam int unsigned CRAM_R_LSB = 0;
  localparam int unsigned CRAM_G_LSB = 2;
  localparam int unsigned CRAM_B_LSB = 4;

  localparam logic [3:0]  TRANSPARENT  = 4'd0;
  localparam int unsigned LEFT_BLANK_W = 8;

  function automatic logic [3:0] expand2(input logic [1:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/video_scanout_cram.sv
// 32x6 colour RAM: one write port, a registered scan-out read port and, when
// VIDEO_CRAM_READBACK_EN is defined, a second registered read port for CPU readback.
module cram_dp
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic       rd_a_en,
  input  logic [4:0] rd_a_addr,
  output logic [5:0] rd_a_data
`ifdef VIDEO_CRAM_READBACK_EN
  ,
  input  logic [4:0] rd_b_addr,
  output logic [5:0] rd_b_data
`endif
);

  logic [CRAM_W-1:0] mem [CRAM_DEPTH];
  logic [CRAM_W-1:0] rd_a_q;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Whole-word reads: a write to the entry being read returns old or new, never a mix.
  always_ff @(posedge clk) begin
    if (reset)        rd_a_q <= '0;
    else if (rd_a_en) rd_a_q <= mem[rd_a_addr];
  end

  assign rd_a_data = rd_a_q;

`ifdef VIDEO_CRAM_READBACK_EN
  logic [CRAM_W-1:0] rd_b_q;

  always_ff @(posedge clk) begin
    if (reset) rd_b_q <= '0;
    else       rd_b_q <= mem[rd_b_addr];
  end

  assign rd_b_data = rd_b_q;
`endif

endmodule

// File: rtl/video_scanout.sv
// Raster timing, line-buffer scan-out, CRAM colour lookup, syncs and line/frame IRQs.
// Optional CRAM readback port enabled by defining VIDEO_CRAM_READBACK_EN.
module video_scanout
  import video_pkg::*;
#(
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
  parameter int unsigned H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
  parameter int unsigned V_SYNC_LEN   = V_SYNC_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       display_en,
  input  logic       left_blank,
  input  logic [3:0] backdrop,
  input  logic [7:0] line_irq_reload,
  input  logic       line_irq_ack,
  input  logic       frame_irq_ack,
  input  logic       cram_wr,
  input  logic [4:0] cram_addr,
  input  logic [5:0] cram_wrdata,
  output logic [5:0] cram_rddata,
  output logic       render_start,
  output logic [7:0] render_line,
  output logic [7:0] linebuf_rdidx,
  input  logic [4:0] linebuf_data,
  output logic [8:0] vcount,
  output logic       line_irq,
  output logic       frame_irq,
  output logic [3:0] video_r,
  output logic [3:0] video_g,
  output logic [3:0] video_b,
  output logic       video_hs,
  output logic       video_vs,
  output logic       video_de
);

  localparam logic [8:0] HTotalM1   = 9'(H_TOTAL - 1);
  localparam logic [8:0] HActive    = 9'(H_ACTIVE);
  localparam logic [8:0] HSyncStart = 9'(H_SYNC_START);
  localparam logic [8:0] HSyncEnd   = 9'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [8:0] VTotalM1   = 9'(V_TOTAL - 1);
  localparam logic [8:0] VActive    = 9'(V_ACTIVE);
  localparam logic [8:0] VSyncStart = 9'(V_SYNC_START);
  localparam logic [8:0] VSyncEnd   = 9'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [8:0] LeftBlankW = 9'(LEFT_BLANK_W);

  logic [8:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       h_last, v_last;
  logic [8:0] next_line;
  logic       line_start, render_req;
  logic       primed_q, render_start_q;
  logic [7:0] render_line_q;
  logic       act1_q, blank1_q, hs1_q, vs1_q;
  logic       de2_q, hs2_q, vs2_q;
  logic [3:0] colour;
  logic       use_backdrop;
  logic [4:0] pix_idx;
  logic [5:0] cram_q;
  logic [7:0] line_cnt_q, line_cnt_d;
  logic       irq_point, line_set, frame_set;
  logic       line_irq_q, frame_irq_q;

  assign h_last = (hcnt_q == HTotalM1);
  assign v_last = (vcnt_q == VTotalM1);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce) begin
      hcnt_d = h_last ? '0 : hcnt_q + 9'd1;
      if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 9'd1;
    end
  end

  // After reset the renderer has no valid line yet, so requests start with line 0
  // of the next frame (issued at the start of the last line).
  assign line_start = pix_ce && (hcnt_q == '0);
  assign next_line  = v_last ? '0 : vcnt_q + 9'd1;
  assign render_req = line_start && (next_line < VActive) && (primed_q || v_last);

  assign colour       = linebuf_data[3:0];
  assign use_backdrop = (colour == TRANSPARENT) || !display_en || (left_blank && blank1_q);
  assign pix_idx      = use_backdrop ? {1'b1, backdrop} : linebuf_data;

  assign irq_point = pix_ce && (hcnt_q == HActive);
  assign frame_set = irq_point && (vcnt_q == VActive);

  always_comb begin
    line_cnt_d = line_cnt_q;
    line_set   = 1'b0;
    if (irq_point) begin
      if (vcnt_q <= VActive) begin
        if (line_cnt_q == '0) begin
          line_set   = 1'b1;
          line_cnt_d = line_irq_reload;
        end else begin
          line_cnt_d = line_cnt_q - 8'd1;
        end
      end else begin
        line_cnt_d = line_irq_reload;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      primed_q       <= 1'b0;
      render_start_q <= 1'b0;
      render_line_q  <= '0;
      act1_q         <= 1'b0;
      blank1_q       <= 1'b0;
      hs1_q          <= 1'b0;
      vs1_q          <= 1'b0;
      de2_q          <= 1'b0;
      hs2_q          <= 1'b0;
      vs2_q          <= 1'b0;
      line_cnt_q     <= line_irq_reload;
      line_irq_q     <= 1'b0;
      frame_irq_q    <= 1'b0;
    end else begin
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      render_start_q <= render_req;
      if (render_req) render_line_q <= next_line[7:0];
      if (line_start && v_last) primed_q <= 1'b1;
      if (pix_ce) begin
        act1_q   <= (hcnt_q < HActive) && (vcnt_q < VActive);
        blank1_q <= (hcnt_q < LeftBlankW);
        hs1_q    <= (hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd);
        vs1_q    <= (vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd);
        de2_q    <= act1_q;
        hs2_q    <= hs1_q;
        vs2_q    <= vs1_q;
      end
      line_cnt_q <= line_cnt_d;
      // Setting has priority over a simultaneous acknowledge.
      if (line_set)          line_irq_q  <= 1'b1;
      else if (line_irq_ack) line_irq_q  <= 1'b0;
      if (frame_set)          frame_irq_q <= 1'b1;
      else if (frame_irq_ack) frame_irq_q <= 1'b0;
    end
  end

  cram_dp u_cram (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cram_wr),
    .wr_addr  (cram_addr),
    .wr_data  (cram_wrdata),
    .rd_a_en  (pix_ce),
    .rd_a_addr(pix_idx),
    .rd_a_data(cram_q)
`ifdef VIDEO_CRAM_READBACK_EN
    ,
    .rd_b_addr(cram_addr),
    .rd_b_data(cram_rddata)
`endif
  );

`ifdef VIDEO_CRAM_READBACK_EN
`else
  assign cram_rddata = '0;
`endif

  assign linebuf_rdidx = hcnt_q[7:0];
  assign vcount        = vcnt_q;
  assign render_start  = render_start_q;
  assign render_line   = render_line_q;
  assign line_irq      = line_irq_q;
  assign frame_irq     = frame_irq_q;
  assign video_de      = de2_q;
  assign video_hs      = hs2_q;
  assign video_vs      = vs2_q;
  assign video_r       = de2_q ? expand2(cram_q[CRAM_R_LSB +: 2]) : 4'h0;
  assign video_g       = de2_q ? expand2(cram_q[CRAM_G_LSB +: 2]) : 4'h0;
  assign video_b       = de2_q ? expand2(cram_q[CRAM_B_LSB +: 2]) : 4'h0;

endmodule

// File: tb/tb_video_scanout.sv
// Directed self-checking bench for video_scanout; honours VIDEO_CRAM_READBACK_EN.
module tb_video_scanout;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_ce = 1'b1;
  logic       display_en = 1'b1;
  logic       left_blank = 1'b0;
  logic [3:0] backdrop = 4'd0;
  logic [7:0] line_irq_reload = 8'd0;
  logic       line_irq_ack = 1'b0;
  logic       frame_irq_ack = 1'b0;
  logic       cram_wr = 1'b0;
  logic [4:0] cram_addr = 5'd0;
  logic [5:0] cram_wrdata = 6'd0;
  logic [5:0] cram_rddata;
  logic       render_start;
  logic [7:0] render_line;
  logic [7:0] linebuf_rdidx;
  logic [4:0] linebuf_data = 5'd0;
  logic [8:0] vcount;
  logic       line_irq, frame_irq;
  logic [3:0] video_r, video_g, video_b;
  logic       video_hs, video_vs, video_de;

  int checks = 0;
  int errors = 0;

  logic [4:0] lb_mem [256];

  always #5 clk = ~clk;

  // Line buffer model with one clock of read latency
  always @(posedge clk) linebuf_data <= lb_mem[linebuf_rdidx];

  video_scanout dut (
    .clk            (clk),
    .reset          (reset),
    .pix_ce         (pix_ce),
    .display_en     (display_en),
    .left_blank     (left_blank),
    .backdrop       (backdrop),
    .line_irq_reload(line_irq_reload),
    .line_irq_ack   (line_irq_ack),
    .frame_irq_ack  (frame_irq_ack),
    .cram_wr        (cram_wr),
    .cram_addr      (cram_addr),
    .cram_wrdata    (cram_wrdata),
    .cram_rddata    (cram_rddata),
    .render_start   (render_start),
    .render_line    (render_line),
    .linebuf_rdidx  (linebuf_rdidx),
    .linebuf_data   (linebuf_data),
    .vcount         (vcount),
    .line_irq       (line_irq),
    .frame_irq      (frame_irq),
    .video_r        (video_r),
    .video_g        (video_g),
    .video_b        (video_b),
    .video_hs       (video_hs),
    .video_vs       (video_vs),
    .video_de       (video_de)
  );

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_cram(input logic [4:0] a, input logic [5:0] d);
    @(negedge clk);
    cram_wr = 1'b1;
    cram_addr = a;
    cram_wrdata = d;
    @(negedge clk);
    cram_wr = 1'b0;
  endtask

  task automatic fill_lb(input logic [4:0] v);
    for (int i = 0; i < 256; i++) lb_mem[i] = v;
  endtask

  task automatic wait_de(input logic level, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (video_de === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    line_irq_reload = 8'd0;
    fill_lb(5'd0);
    do_reset;
    repeat (290) @(negedge clk);
    checks++;
    if (video_hs !== 1'b1) begin
      errors++; $display("FAIL pre_reset_hs: got %b want 1", video_hs);
    end
    checks++;
    if (line_irq !== 1'b1) begin
      errors++; $display("FAIL pre_reset_line_irq: got %b want 1", line_irq);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (vcount !== 9'd0 || linebuf_rdidx !== 8'd0) begin
      errors++; $display("FAIL reset_counters: vcount %0d rdidx %0d want 0 0", vcount, linebuf_rdidx);
    end
    checks++;
    if ({video_r, video_g, video_b} !== 12'h000 || {video_hs, video_vs, video_de} !== 3'b000) begin
      errors++;
      $display("FAIL reset_video: rgb %h hs/vs/de %b%b%b want 000 000",
               {video_r, video_g, video_b}, video_hs, video_vs, video_de);
    end
    checks++;
    if ({render_start, render_line} !== 9'd0 || {line_irq, frame_irq} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: rs %b rl %0d irq %b%b want 0 0 00",
               render_start, render_line, line_irq, frame_irq);
    end
    checks++;
    if (cram_rddata !== 6'd0) begin
      errors++; $display("FAIL reset_rddata: got %h want 00", cram_rddata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (video_de !== 1'b0) begin
      errors++; $display("FAIL latency_de_c1: got %b want 0", video_de);
    end
    @(negedge clk);
    checks++;
    if (video_de !== 1'b1) begin
      errors++; $display("FAIL latency_de_c2: got %b want 1", video_de);
    end
  endtask

  task automatic test_colour;
    logic ok;
    fill_lb(5'd0);
    lb_mem[10] = 5'h12;
    backdrop = 4'd3;
    display_en = 1'b1;
    left_blank = 1'b0;
    write_cram(5'h13, 6'b110110);
    write_cram(5'h12, 6'b000111);
    do_reset;
    wait_de(1'b1, ok);
    checks++;
    if (!ok || {video_r, video_g, video_b} !== 12'hA5F) begin
      errors++; $display("FAIL backdrop_px0: ok %b rgb %h want A5F", ok, {video_r, video_g, video_b});
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({video_r, video_g, video_b} !== 12'hF50) begin
      errors++; $display("FAIL palette_px10: rgb %h want F50", {video_r, video_g, video_b});
    end
    wait_de(1'b0, ok);
    checks++;
    if (!ok || {video_r, video_g, video_b} !== 12'h000) begin
      errors++; $display("FAIL inactive_rgb: ok %b rgb %h want 000", ok, {video_r, video_g, video_b});
    end
    display_en = 1'b0;
    wait_de(1'b1, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || {video_r, video_g, video_b} !== 12'hA5F) begin
      errors++;
      $display("FAIL display_off_px10: ok %b rgb %h want A5F", ok, {video_r, video_g, video_b});
    end
    display_en = 1'b1;
  endtask

  task automatic test_left_blank;
    int px;
    logic ce_last;
    logic [11:0] want;
    logic [12:0] prev;
    fill_lb(5'h05);
    backdrop = 4'd0;
    left_blank = 1'b1;
    write_cram(5'h05, 6'h3F);
    write_cram(5'h10, 6'h00);
    do_reset;
    px = 0;
    prev = {video_de, video_r, video_g, video_b};
    // pix_ce toggles every clock; outputs must hold on idle clocks
    for (int c = 0; c < 1400 && px < 256; c++) begin
      @(negedge clk);
      ce_last = pix_ce;
      pix_ce = c[0];
      if (!ce_last) begin
        checks++;
        if ({video_de, video_r, video_g, video_b} !== prev) begin
          errors++;
          $display("FAIL ce_hold: got %h want %h", {video_de, video_r, video_g, video_b}, prev);
        end
      end else if (video_de) begin
        want = (px < 8) ? 12'h000 : 12'hFFF;
        checks++;
        if ({video_r, video_g, video_b} !== want) begin
          errors++;
          $display("FAIL left_blank_px%0d: rgb %h want %h", px, {video_r, video_g, video_b}, want);
        end
        px++;
      end
      prev = {video_de, video_r, video_g, video_b};
    end
    checks++;
    if (px !== 256) begin
      errors++; $display("FAIL left_blank_count: pixels %0d want 256", px);
    end
    pix_ce = 1'b1;
    left_blank = 1'b0;
  endtask

  task automatic test_line_irq;
    int rises;
    logic li_p;
    logic want;
    line_irq_reload = 8'd2;
    pix_ce = 1'b1;
    do_reset;
    rises = 0;
    li_p = 1'b0;
    for (int c = 1; c <= 2993; c++) begin
      @(negedge clk);
      line_irq_ack = 1'b0;
      if (line_irq && !li_p) rises++;
      li_p = line_irq;
      if (c == 940 || c == 941 || c == 942 || c == 1966 || c == 1967 || c == 1968 ||
          c == 1969 || c == 2992 || c == 2993) begin
        want = (c == 941 || c == 1967 || c == 1968 || c == 2993);
        checks++;
        if (line_irq !== want) begin
          errors++; $display("FAIL line_irq_c%0d: got %b want %b", c, line_irq, want);
        end
      end
      // 1966: ack lands on the same clock as the line-5 set
      if (c == 941 || c == 1966 || c == 1968) line_irq_ack = 1'b1;
    end
    line_irq_ack = 1'b0;
    checks++;
    if (rises !== 3) begin
      errors++; $display("FAIL line_irq_rises: got %0d want 3", rises);
    end
  endtask

  task automatic test_readback;
    write_cram(5'h07, 6'h2A);
    @(negedge clk);
`ifdef VIDEO_CRAM_READBACK_EN
    checks++;
    if (cram_rddata !== 6'h2A) begin
      errors++; $display("FAIL readback_7: got %h want 2A", cram_rddata);
    end
    cram_addr = 5'h13;
    @(negedge clk);
    checks++;
    if (cram_rddata !== 6'h36) begin
      errors++; $display("FAIL readback_13: got %h want 36", cram_rddata);
    end
`else
    checks++;
    if (cram_rddata !== 6'h00) begin
      errors++; $display("FAIL readback_off_7: got %h want 00", cram_rddata);
    end
    cram_addr = 5'h13;
    @(negedge clk);
    checks++;
    if (cram_rddata !== 6'h00) begin
      errors++; $display("FAIL readback_off_13: got %h want 00", cram_rddata);
    end
`endif
  endtask

  task automatic test_frame;
    int hs_rises, hs_last, hs_bad, de_total, de_rises, vs_cycles, vs_line;
    int fr_rises, fr_line, li_rises, li_line, rs_cnt;
    int rs_v [2];
    int rs_l [2];
    logic hs_p, de_p, vs_p, fr_p, li_p, done;
    line_irq_reload = 8'd0;
    pix_ce = 1'b1;
    fill_lb(5'd0);
    do_reset;
    {hs_rises, hs_last, hs_bad, de_total, de_rises, vs_cycles, vs_line} = '0;
    {fr_rises, fr_line, li_rises, li_line, rs_cnt} = '0;
    rs_v[0] = -1; rs_v[1] = -1; rs_l[0] = -1; rs_l[1] = -1;
    {hs_p, de_p, vs_p, fr_p, li_p, done} = '0;
    for (int c = 1; c <= 90000 && !done; c++) begin
      @(negedge clk);
      line_irq_ack = 1'b0;
      if (video_hs && !hs_p) begin
        if (hs_rises > 0 && (c - hs_last) != 342) hs_bad++;
        hs_last = c;
        hs_rises++;
      end
      if (video_de) de_total++;
      if (video_de && !de_p) de_rises++;
      if (video_vs) vs_cycles++;
      if (video_vs && !vs_p) vs_line = int'(vcount);
      if (frame_irq && !fr_p) begin fr_rises++; fr_line = int'(vcount); end
      if (line_irq && !li_p) begin li_rises++; li_line = int'(vcount); end
      if (line_irq) line_irq_ack = 1'b1;
      if (render_start) begin
        if (rs_cnt < 2) begin rs_v[rs_cnt] = int'(vcount); rs_l[rs_cnt] = int'(render_line); end
        rs_cnt++;
        if (render_line == 8'd1) done = 1'b1;
      end
      {hs_p, de_p, vs_p, fr_p, li_p} = {video_hs, video_de, video_vs, frame_irq, line_irq};
    end
    line_irq_ack = 1'b0;
    checks++;
    if (hs_rises !== 262 || hs_bad !== 0) begin
      errors++; $display("FAIL hs_period: rises %0d bad %0d want 262 0", hs_rises, hs_bad);
    end
    checks++;
    if (de_total !== 256 * 192 || de_rises !== 192) begin
      errors++; $display("FAIL de_area: total %0d lines %0d want 49152 192", de_total, de_rises);
    end
    checks++;
    if (vs_cycles !== 3 * 342 || vs_line !== 216) begin
      errors++; $display("FAIL vsync: cycles %0d line %0d want 1026 216", vs_cycles, vs_line);
    end
    checks++;
    if (fr_rises !== 1 || fr_line !== 192) begin
      errors++; $display("FAIL frame_irq: rises %0d line %0d want 1 192", fr_rises, fr_line);
    end
    checks++;
    if (li_rises !== 193 || li_line !== 192) begin
      errors++; $display("FAIL line_irq_all: rises %0d last %0d want 193 192", li_rises, li_line);
    end
    checks++;
    if (rs_cnt !== 2) begin
      errors++; $display("FAIL render_count: pulses %0d want 2", rs_cnt);
    end
    checks++;
    if (rs_v[0] !== 261 || rs_l[0] !== 0) begin
      errors++; $display("FAIL render_first: vcount %0d line %0d want 261 0", rs_v[0], rs_l[0]);
    end
    checks++;
    if (rs_v[1] !== 0 || rs_l[1] !== 1) begin
      errors++; $display("FAIL render_second: vcount %0d line %0d want 0 1", rs_v[1], rs_l[1]);
    end
  endtask

  initial begin
    fill_lb(5'd0);
    test_reset;
    test_colour;
    test_left_blank;
    test_line_irq;
    test_readback;
    test_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
